// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, destination select, E->M control register.
// Build option: define EXECUTE_NOR_EN to make ALUControlE=011 compute NOR.
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  forwardAE,
    input  logic [1:0]  forwardBE,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] ResultW,
    input  logic        RegWriteE,
    input  logic        MemToRegE,
    input  logic        MemWriteE,
    input  logic        jumpE,
    input  logic [2:0]  ALUControlE,
    input  logic        ALUSrcE,
    input  logic        RegDstE,
    input  logic [4:0]  RsE,
    input  logic [4:0]  RtE,
    input  logic [4:0]  RdE,
    input  logic [31:0] SignImmE,
    output logic        RegWriteM,
    output logic        MemToRegM,
    output logic        MemWriteM,
    output logic        jumpM,
    output logic [4:0]  WriteRegE,
    output logic [31:0] WriteDataE,
    output logic [31:0] ALUOutE
);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic        rs_unused;

    // RsE only feeds the hazard unit outside this stage
    assign rs_unused = ^RsE;

    always_comb begin
        src_a = rd1;
        unique case (forwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUOutM;
            default: src_a = rd1;
        endcase
    end

    always_comb begin
        fwd_b = rd2;
        unique case (forwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUOutM;
            default: fwd_b = rd2;
        endcase
    end

    assign src_b      = ALUSrcE ? SignImmE : fwd_b;
    assign WriteDataE = fwd_b;
    assign WriteRegE  = RegDstE ? RdE : RtE;

    always_comb begin
        ALUOutE = 32'h0000_0000;
        unique case (ALUControlE)
            3'b000: ALUOutE = src_a & src_b;
            3'b001: ALUOutE = src_a | src_b;
            3'b010: ALUOutE = src_a + src_b;
`ifdef EXECUTE_NOR_EN
            3'b011: ALUOutE = ~(src_a | src_b);
`else
            3'b011: ALUOutE = 32'h0000_0000;
`endif
            3'b100: ALUOutE = src_a & ~src_b;
            3'b101: ALUOutE = src_a | ~src_b;
            3'b110: ALUOutE = src_a - src_b;
            3'b111: ALUOutE = {31'd0, $signed(src_a) < $signed(src_b)};
            default: ALUOutE = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM <= 1'b0;
            MemToRegM <= 1'b0;
            MemWriteM <= 1'b0;
            jumpM     <= 1'b0;
        end else begin
            RegWriteM <= RegWriteE;
            MemToRegM <= MemToRegE;
            MemWriteM <= MemWriteE;
            jumpM     <= jumpE;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage.
// Expected values are hand-computed constants per step.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  forwardAE, forwardBE;
    logic [31:0] rd1, rd2, ALUOutM, ResultW, SignImmE;
    logic        RegWriteE, MemToRegE, MemWriteE, jumpE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE, RegDstE;
    logic [4:0]  RsE, RtE, RdE;
    logic        RegWriteM, MemToRegM, MemWriteM, jumpM;
    logic [4:0]  WriteRegE;
    logic [31:0] WriteDataE, ALUOutE;

    int checks = 0;
    int errors = 0;

    execute dut (
        .clk(clk), .rst(rst),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .rd1(rd1), .rd2(rd2), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
        .MemWriteE(MemWriteE), .jumpE(jumpE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .RsE(RsE), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
        .MemWriteM(MemWriteM), .jumpM(jumpM),
        .WriteRegE(WriteRegE), .WriteDataE(WriteDataE), .ALUOutE(ALUOutE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        ALUSrcE = 1'b0;
        rd1 = a;
        rd2 = b;
        ALUControlE = op;
        #1;
    endtask

    function automatic logic [31:0] mvec();
        return {28'd0, RegWriteM, MemToRegM, MemWriteM, jumpM};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        forwardAE = 2'b00; forwardBE = 2'b00;
        rd1 = 0; rd2 = 0; ALUOutM = 0; ResultW = 0; SignImmE = 0;
        RegWriteE = 1'b1; MemToRegE = 1'b1; MemWriteE = 1'b1; jumpE = 1'b1;
        ALUControlE = 3'b000; ALUSrcE = 1'b0; RegDstE = 1'b0;
        RsE = 5'd0; RtE = 5'd0; RdE = 5'd0;

        // reset held across edges with all E controls high
        repeat (2) @(posedge clk);
        #1;
        check("reset_m", mvec(), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        RegWriteE = 1'b0; MemToRegE = 1'b0; MemWriteE = 1'b0; jumpE = 1'b0;

        // forwarding of operand A
        rd1 = 5; ALUOutM = 9; ResultW = 7; rd2 = 3;
        ALUSrcE = 1'b0; ALUControlE = 3'b010; forwardBE = 2'b00;
        forwardAE = 2'b00; #1; check("fwdA_00", ALUOutE, 32'd8);
        forwardAE = 2'b01; #1; check("fwdA_01", ALUOutE, 32'd10);
        forwardAE = 2'b10; #1; check("fwdA_10", ALUOutE, 32'd12);
        forwardAE = 2'b11; #1; check("fwdA_11", ALUOutE, 32'd8);

        // forwarding of operand B
        forwardAE = 2'b00;
        forwardBE = 2'b10; #1;
        check("fwdB_10_alu", ALUOutE, 32'd14);
        check("fwdB_10_wd", WriteDataE, 32'd9);
        forwardBE = 2'b01; #1;
        check("fwdB_01_wd", WriteDataE, 32'd7);
        forwardBE = 2'b11; #1;
        check("fwdB_11_wd", WriteDataE, 32'd3);

        // immediate operand, store data stays rd2
        forwardBE = 2'b00; ALUSrcE = 1'b1; SignImmE = 32'hFFFF_FFFC;
        rd1 = 32'd16; rd2 = 32'h0000_00AB; ALUControlE = 3'b010; #1;
        check("imm_add", ALUOutE, 32'd12);
        check("imm_wd", WriteDataE, 32'h0000_00AB);

        // logic ops
        alu(3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("and", ALUOutE, 32'h00F0_1234);
        alu(3'b001, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("or", ALUOutE, 32'hFFF0_FFFF);
        alu(3'b100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("andn", ALUOutE, 32'hF000_0000);
        alu(3'b101, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("orn", ALUOutE, 32'hF0FF_1234);

        // arithmetic and signed compare
        alu(3'b010, 32'hFFFF_FFFF, 32'd2);
        check("add_wrap", ALUOutE, 32'd1);
        alu(3'b111, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg", ALUOutE, 32'd1);
        alu(3'b110, 32'hFFFF_FFFF, 32'd1);
        check("sub", ALUOutE, 32'hFFFF_FFFE);
        alu(3'b111, 32'd1, 32'hFFFF_FFFF);
        check("slt_pos", ALUOutE, 32'd0);
        alu(3'b111, 32'h8000_0000, 32'h7FFF_FFFF);
        check("slt_min", ALUOutE, 32'd1);
        alu(3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        check("slt_max", ALUOutE, 32'd0);
        alu(3'b111, 32'd5, 32'd5);
        check("slt_eq", ALUOutE, 32'd0);
        alu(3'b110, 32'd0, 32'd1);
        check("sub_wrap", ALUOutE, 32'hFFFF_FFFF);

        // op 011 depends on build option
        alu(3'b011, 32'd0, 32'd0);
`ifdef EXECUTE_NOR_EN
        check("op011", ALUOutE, 32'hFFFF_FFFF);
`else
        check("op011", ALUOutE, 32'h0000_0000);
`endif

        // destination select
        RtE = 5'd3; RdE = 5'd17; RsE = 5'd9;
        RegDstE = 1'b0; #1; check("dst_rt", {27'd0, WriteRegE}, 32'd3);
        RegDstE = 1'b1; #1; check("dst_rd", {27'd0, WriteRegE}, 32'd17);

        // control pipeline: one-cycle latency
        @(negedge clk);
        RegWriteE = 1'b1; jumpE = 1'b1; #1;
        check("ctl_pre", mvec(), 32'h0);
        @(posedge clk); #1;
        check("ctl_post", mvec(), 32'h9);
        MemToRegE = 1'b1; MemWriteE = 1'b1; RegWriteE = 1'b0; jumpE = 1'b0;
        @(posedge clk); #1;
        check("ctl_swap", mvec(), 32'h6);

        // async reset mid-cycle, combinational outputs unaffected
        RegWriteE = 1'b1; jumpE = 1'b1;
        @(posedge clk); #1;
        check("ctl_all", mvec(), 32'hF);
        #2; rst = 1'b1; #1;
        check("rst_async", mvec(), 32'h0);
        check("rst_comb", {27'd0, WriteRegE}, 32'd17);
        @(negedge clk);
        rst = 1'b0; MemWriteE = 1'b0; #1;
        check("rst_hold", mvec(), 32'h0);
        @(posedge clk); #1;
        check("rst_resume", mvec(), 32'hD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
